// File: rtl/m_addr_decoder_wp_if.sv
// Bus interface for m_addr_decoder_wp.
//  master : CPU side, drives addr/MEMLOAD/boot_done/fault_clr, observes the decode results
//  slave  : decoder side, drives sel, load_*, mmr_offset, locked, fault, fault_addr
//           (+ fault_cnt when M_ADDR_FAULT_CNT_EN is defined)
interface m_addr_decoder_wp_if #(
   parameter int unsigned ADDR_W = 12
);
   localparam int unsigned CNT_W = 8;

   logic [ADDR_W-1:0] addr;
   logic              MEMLOAD;
   logic              boot_done;
   logic              fault_clr;
   logic [1:0]        sel;
   logic              load_instr;
   logic              load_mmr;
   logic              load_stack;
   logic [ADDR_W-1:0] mmr_offset;
   logic              locked;
   logic              fault;
   logic [ADDR_W-1:0] fault_addr;
`ifdef M_ADDR_FAULT_CNT_EN
   logic [CNT_W-1:0]  fault_cnt;
`endif

   modport master (
      output addr, MEMLOAD, boot_done, fault_clr,
      input  sel, load_instr, load_mmr, load_stack, mmr_offset, locked, fault, fault_addr
`ifdef M_ADDR_FAULT_CNT_EN
      , input fault_cnt
`endif
   );

   modport slave (
      input  addr, MEMLOAD, boot_done, fault_clr,
      output sel, load_instr, load_mmr, load_stack, mmr_offset, locked, fault, fault_addr
`ifdef M_ADDR_FAULT_CNT_EN
      , output fault_cnt
`endif
   );
endinterface

// File: rtl/m_addr_decoder_wp.sv
// m_addr_decoder_wp: registered 3-region address decoder (instr / MMR / stack) with an
// instruction-region write-protect FSM (BOOT -> RUN on boot_done; RUN <-> FAULT).
// Ports:
//  clk        system clock, rising edge
//  rst        synchronous active-high reset
//  bus        m_addr_decoder_wp_if.slave: addr, MEMLOAD, boot_done, fault_clr in;
//             sel, load_instr, load_mmr, load_stack, mmr_offset, locked, fault, fault_addr out
// Optional: define M_ADDR_FAULT_CNT_EN to add bus.fault_cnt, a saturating 8-bit count of
// blocked writes that clears on rst only.
module m_addr_decoder_wp #(
   parameter int unsigned       ADDR_W    = 12,
   parameter logic [ADDR_W-1:0] INSTR_TOP = ADDR_W'('h400),
   parameter logic [ADDR_W-1:0] MMR_TOP   = ADDR_W'('h44B)
) (
   input logic              clk,
   input logic              rst,
   m_addr_decoder_wp_if.slave bus
);
   localparam longint unsigned ADDR_MAX = (64'd1 << ADDR_W) - 64'd1;
   localparam logic [ADDR_W-1:0] MMR_BASE = INSTR_TOP + ADDR_W'(1);
   localparam logic [1:0] SEL_INSTR = 2'd0;
   localparam logic [1:0] SEL_MMR   = 2'd1;
   localparam logic [1:0] SEL_STACK = 2'd2;
   localparam int unsigned CNT_W    = 8;

   // Region map must be strictly ordered with a non-empty stack region
   if (!((64'(INSTR_TOP) < 64'(MMR_TOP)) && (64'(MMR_TOP) < ADDR_MAX))) begin : g_bad_params
      $fatal(1, "m_addr_decoder_wp: require INSTR_TOP < MMR_TOP < 2**ADDR_W-1");
   end

   typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [1:0]        region_c;
   logic              illegal_c;
   logic [ADDR_W-1:0] offset_c;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= BOOT;
      else     state <= state_nxt;
   end

   // Region decode, write-permission check and next state
   always_comb begin
      state_nxt = state;
      region_c  = SEL_STACK;
      offset_c  = '0;
      if (bus.addr <= INSTR_TOP) begin
         region_c = SEL_INSTR;
      end else if (bus.addr <= MMR_TOP) begin
         region_c = SEL_MMR;
         offset_c = bus.addr - MMR_BASE;
      end
      // Instruction writes are only legal before boot completes
      illegal_c = bus.MEMLOAD && (region_c == SEL_INSTR) && (state != BOOT);
      case (state)
         BOOT:    if (bus.boot_done) state_nxt = RUN;
         RUN:     if (illegal_c) state_nxt = FAULT;
         FAULT:   if (!illegal_c && bus.fault_clr) state_nxt = RUN;
         default: state_nxt = BOOT;
      endcase
   end

   // Registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.sel        <= SEL_INSTR;
         bus.load_instr <= 1'b0;
         bus.load_mmr   <= 1'b0;
         bus.load_stack <= 1'b0;
         bus.mmr_offset <= '0;
         bus.locked     <= 1'b0;
         bus.fault      <= 1'b0;
         bus.fault_addr <= '0;
      end else begin
         bus.sel        <= region_c;
         bus.load_instr <= bus.MEMLOAD && (region_c == SEL_INSTR) && (state == BOOT);
         bus.load_mmr   <= bus.MEMLOAD && (region_c == SEL_MMR);
         bus.load_stack <= bus.MEMLOAD && (region_c == SEL_STACK);
         bus.mmr_offset <= offset_c;
         bus.locked     <= (state_nxt != BOOT);
         bus.fault      <= (state_nxt == FAULT);
         if (illegal_c) bus.fault_addr <= bus.addr;
      end
   end

`ifdef M_ADDR_FAULT_CNT_EN
   // Saturating blocked-write counter; survives fault_clr
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.fault_cnt <= '0;
      end else if (illegal_c && (bus.fault_cnt != {CNT_W{1'b1}})) begin
         bus.fault_cnt <= bus.fault_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_m_addr_decoder_wp.sv
// Self-checking bench for m_addr_decoder_wp: directed scenarios plus a random phase, all
// predicted by a behavioural model of the region map and the write-protect rules.
module tb_m_addr_decoder_wp;
   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   m_addr_decoder_wp_if #(.ADDR_W(12)) bus ();

   m_addr_decoder_wp #(
      .ADDR_W   (12),
      .INSTR_TOP(12'h400),
      .MMR_TOP  (12'h44B)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state
   bit          booted;
   bit          flt;
   logic [11:0] faddr;
   int          cnt;
   // Expected outputs
   logic [1:0]  e_sel;
   bit          e_li, e_lm, e_ls;
   logic [11:0] e_off;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, check every output after the edge
   task automatic step(input string tag, input logic [11:0] a, input bit ml,
                       input bit bd, input bit fc, input bit r);
      int  region;
      bit  illegal;
      @(negedge clk);
      rst           = r;
      bus.addr      = a;
      bus.MEMLOAD   = ml;
      bus.boot_done = bd;
      bus.fault_clr = fc;
      if (r) begin
         e_sel = 2'd0; e_li = 0; e_lm = 0; e_ls = 0; e_off = 12'h000;
         booted = 0; flt = 0; faddr = 12'h000; cnt = 0;
      end else begin
         region  = (a <= 12'h400) ? 0 : (a <= 12'h44B) ? 1 : 2;
         illegal = ml && region == 0 && booted;
         e_sel   = 2'(region);
         e_li    = ml && region == 0 && !booted;
         e_lm    = ml && region == 1;
         e_ls    = ml && region == 2;
         e_off   = (region == 1) ? a - 12'h401 : 12'h000;
         if (illegal) begin
            flt = 1; faddr = a;
            if (cnt < 255) cnt++;
         end else if (flt && fc) begin
            flt = 0;
         end
         if (bd) booted = 1;
      end
      @(posedge clk);
      #1;
      if (bus.sel !== e_sel || bus.load_instr !== e_li || bus.load_mmr !== e_lm ||
          bus.load_stack !== e_ls || bus.mmr_offset !== e_off) begin
         chk({tag, ".sel"},        32'(bus.sel),        32'(e_sel));
         chk({tag, ".load_instr"}, 32'(bus.load_instr), 32'(e_li));
         chk({tag, ".load_mmr"},   32'(bus.load_mmr),   32'(e_lm));
         chk({tag, ".load_stack"}, 32'(bus.load_stack), 32'(e_ls));
         chk({tag, ".mmr_offset"}, 32'(bus.mmr_offset), 32'(e_off));
      end else begin
         chk({tag, ".decode"}, {16'(bus.sel), 4'(bus.load_instr), 4'(bus.load_mmr),
             8'(bus.load_stack)}, {16'(e_sel), 4'(e_li), 4'(e_lm), 8'(e_ls)});
         chk({tag, ".mmr_offset"}, 32'(bus.mmr_offset), 32'(e_off));
      end
      chk({tag, ".locked"},     32'(bus.locked),     32'(booted));
      chk({tag, ".fault"},      32'(bus.fault),      32'(flt));
      chk({tag, ".fault_addr"}, 32'(bus.fault_addr), 32'(faddr));
      chk({tag, ".state"},      32'(dut.state),      !booted ? 32'd0 : flt ? 32'd2 : 32'd1);
`ifdef M_ADDR_FAULT_CNT_EN
      chk({tag, ".fault_cnt"},  32'(bus.fault_cnt),  32'(cnt));
`endif
   endtask

   logic [11:0] edges [8];

   initial begin
      rst = 1'b1;
      bus.addr = '0; bus.MEMLOAD = 0; bus.boot_done = 0; bus.fault_clr = 0;
      edges = '{12'h000, 12'h400, 12'h401, 12'h44B, 12'h44C, 12'hFFF, 12'h123, 12'h010};

      // Reset state, with write/boot/clear inputs active that must be overridden
      step("reset", 12'h010, 1, 1, 1, 1);
      chk("reset.state_boot", 32'(dut.state), 32'd0);

      // Exhaustive sweep in BOOT: every address written once
      for (int i = 0; i < 4096; i++) step("sweep", 12'(i), 1, 0, 0, 0);
      chk("sweep.still_unlocked", 32'(bus.locked), 32'd0);

      // Lock, then an illegal write
      step("boot_done", 12'h000, 0, 1, 0, 0);
      step("ill_123", 12'h123, 1, 0, 0, 0);
      chk("ill_123.faddr_const", 32'(bus.fault_addr), 32'h123);
      step("read_instr", 12'h200, 0, 0, 0, 0);
      step("flt_mmr_top", 12'h44B, 1, 0, 0, 0);
      chk("flt_mmr_top.load_mmr", 32'(bus.load_mmr), 32'd1);
      step("flt_stack_base", 12'h44C, 1, 0, 0, 0);
      chk("flt_stack_base.load_stack", 32'(bus.load_stack), 32'd1);
      step("boot_in_fault", 12'h44C, 0, 1, 0, 0);
      // Illegal write beats fault_clr
      step("clr_vs_ill", 12'h010, 1, 0, 1, 0);
      chk("clr_vs_ill.faddr_const", 32'(bus.fault_addr), 32'h010);
      step("clr", 12'h010, 0, 0, 1, 0);
      chk("clr.state_run", 32'(dut.state), 32'd1);
      step("ill_again", 12'h400, 1, 0, 0, 0);
      // Reset in FAULT, then a boot-time write to 0
      step("rst_in_fault", 12'h000, 1, 0, 1, 1);
      step("post_rst_w0", 12'h000, 1, 0, 0, 0);
      chk("post_rst_w0.load_instr", 32'(bus.load_instr), 32'd1);

      // Many illegal writes in RUN/FAULT, then a clear
      step("boot_done2", 12'h000, 0, 1, 0, 0);
      for (int i = 0; i < 300; i++) step("ill_burst", 12'($urandom_range(0, 12'h400)), 1, 0, 0, 0);
      step("burst_clr", 12'h500, 0, 0, 1, 0);
`ifdef M_ADDR_FAULT_CNT_EN
      chk("burst_clr.cnt_sat", 32'(bus.fault_cnt), 32'hFF);
`endif

      // Random phase, addresses biased toward region boundaries
      for (int i = 0; i < 3000; i++) begin
         logic [11:0] a;
         int r;
         r = int'($urandom_range(0, 99));
         if ($urandom_range(0, 1) == 0) a = edges[$urandom_range(0, 7)];
         else                           a = 12'($urandom);
         step("rand", a, $urandom_range(0, 3) != 0, r >= 2 && r < 5,
              $urandom_range(0, 3) == 0, r < 2);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
